ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Parametrised instruction-fetch unit with prefetch buffer. It replaces the single-register PC/fetch path between the program-memory bus and the IF/ID stage, and keeps up to DEPTH instructions in flight or buffered. The program-memory side is a request/grant, in-order-response bus. Jumps flush the buffer and discard stale in-flight responses. The decode side sees a valid/ready stream of instruction and address pairs.

## Interface
Parameters:
- ADDR_W, 32, fetch address width
- INST_W, 32, instruction width
- DEPTH, 4, buffer entries plus outstanding requests; power of 2, ≥2
- RESET_PC, 0, first fetch address after reset
- INST_NOP, 32'h00000013, value driven on inst_o when invalid

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req_o  out  1  fetch request
- fetch_addr_o  out  ADDR_W  fetch address, word aligned
- fetch_gnt_i  in  1  request accepted this cycle
- fetch_rvalid_i  in  1  response valid; responses return in order, ≥1 cycle after grant
- fetch_rdata_i  in  INST_W  response data
- jump_flag_i  in  1  redirect/flush, from ctrl
- jump_addr_i  in  ADDR_W  redirect target
- halt_i  in  1  stop issuing new requests (bus hold, jtag halt)
- inst_valid_o  out  1  head entry valid
- inst_o  out  INST_W  head instruction
- inst_addr_o  out  ADDR_W  head instruction address
- inst_ready_i  in  1  consumer pops the head this cycle

## Operation
- State: issue_pc, fill_pc, FIFO (count), outstanding counter, discard counter. The FIFO entry is {addr, inst}.
- Issue: fetch_req_o = !rst && !halt_i && !jump_flag_i && (count + outstanding < DEPTH). fetch_addr_o = issue_pc. On req&&gnt: issue_pc += 4 and outstanding++.
- Response with discard = 0: push {fill_pc, fetch_rdata_i}, then fill_pc += 4.
- Response with discard > 0: drop the data and decrement discard.
- Any response: outstanding--.
- Grant and response in the same cycle: outstanding is unchanged.
- Pop: inst_valid_o && inst_ready_i. Push and pop in the same cycle are legal at any count, including full.
- jump_flag_i = 1:
  - FIFO count becomes 0.
  - issue_pc and fill_pc become jump_addr_i.
  - discard becomes outstanding minus any response arriving this cycle. That response is dropped.
  - inst_valid_o is forced to 0 in this cycle.
  - Any pop this cycle is ignored.
- Redirect while discard > 0: discard accumulates correctly, and never exceeds outstanding.
- halt_i only blocks issue. Responses and pops continue.
- inst_o = INST_NOP and inst_addr_o = 0 whenever inst_valid_o = 0.
- Counter widths are $clog2(DEPTH+1). Pointers are $clog2(DEPTH) and wrap naturally.

## Timing
- Reset, synchronous and active-high. After the edge with rst = 1:
  - issue_pc = fill_pc = RESET_PC; count = outstanding = discard = 0.
  - fetch_req_o = 0 while rst is high.
  - inst_valid_o = 0, inst_o = INST_NOP, inst_addr_o = 0.
- Reset mid-operation aborts everything. Responses arriving after reset release with outstanding = 0 are illegal; that is a bus protocol violation.
- First request: in the first cycle with rst = 0, addr = RESET_PC.
- Latency: a response in cycle N gives inst_valid_o in cycle N+1, registered with no bypass.
- Best case, grant in cycle 0 and response in cycle 1, gives the instruction in cycle 2.
- Throughput: 1 instruction/cycle sustained when the bus grants every cycle and response latency ≤ DEPTH-1.
- Redirect: jump_flag_i asserted in cycle N gives fetch_req_o = 1 with addr = jump_addr_i in cycle N+1.

## Structure
- Shared package tinyriscv_pkg holds INST_NOP, the instruction-width constant and the address-width constant. The core and this unit both use it.
- One sub-module, prefetch_fifo: a synchronous FIFO, parametrised on width and depth. It has push, pop, flush, count, and head output.
- The top of ifu_prefetch holds issue_pc, fill_pc, the outstanding/discard counters and the issue logic.

## Test plan
- Reset with RESET_PC = 0x100, gnt tied to 1, rvalid one cycle after gnt with data = addr ^ 0xA5A5A5A5, ready = 1:
  - inst_valid_o first in cycle 2, addr 0x100.
  - Then one instruction per cycle at 0x104, 0x108, ….
- Backpressure, DEPTH = 4, ready = 0:
  - Exactly 4 grants are issued, then fetch_req_o = 0.
  - Raising ready pops the entries in order with no loss or duplication.
- Redirect with 3 outstanding requests, jump_addr_i = 0x2000:
  - The 3 later responses are dropped.
  - The next valid instruction has addr 0x2000 and the data of the first post-jump response.
- Back-to-back redirects to 0x40 and then 0x80 while responses are in flight:
  - Only 0x80-stream data appears.
  - outstanding returns to 0 when idle.
- halt_i = 1 for 10 cycles mid-stream:
  - No new grants.
  - Buffered entries still drain.
  - Resume continues at the correct next sequential address.
- Random gnt/rvalid/ready/jump stimulus, 10k cycles, checked against a reference model:
  - Addresses are monotonically +4 between redirects.
  - count + outstanding ≤ DEPTH always.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - shared core constants used by the core and the fetch unit
package tinyriscv_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    // addi x0, x0, 0 -- the canonical RISC-V NOP, shown to decode when nothing is valid
    localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - synchronous FIFO with flush, occupancy count and head output
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push_i     write data_i at the tail (ignored while flush_i)
//   data_i     entry to write
//   pop_i      drop the head entry (ignored when empty or while flush_i)
//   flush_i    empty the FIFO this cycle
//   count_o    number of stored entries, 0..DEPTH
//   head_o     oldest entry (undefined when count_o == 0)
module prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_en;
    logic pop_en;

    assign push_en = push_i && !flush_i;
    assign pop_en  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are power-of-two wide, so they wrap without a compare
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with prefetch buffer and redirect flush
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   fetch_req_o      request to program memory
//   fetch_addr_o     word-aligned fetch address
//   fetch_gnt_i      request accepted this cycle
//   fetch_rvalid_i   in-order response valid
//   fetch_rdata_i    response data
//   jump_flag_i      redirect: flush buffer, drop in-flight responses
//   jump_addr_i      redirect target
//   halt_i           stop issuing new requests
//   inst_valid_o     head instruction valid
//   inst_o           head instruction (NOP when invalid)
//   inst_addr_o      head instruction address (0 when invalid)
//   inst_ready_i     consumer takes the head this cycle
module ifu_prefetch #(
    parameter int                ADDR_W   = tinyriscv_pkg::ADDR_WIDTH,
    parameter int                INST_W   = tinyriscv_pkg::INST_WIDTH,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] INST_NOP = INST_W'(tinyriscv_pkg::INST_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fetch_req_o,
    output logic [ADDR_W-1:0] fetch_addr_o,
    input  logic              fetch_gnt_i,
    input  logic              fetch_rvalid_i,
    input  logic [INST_W-1:0] fetch_rdata_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              halt_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_ready_i
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
    logic [ADDR_W-1:0] fill_pc_q, fill_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_valid;
    logic [CNT_W:0]     in_use;
    logic               grant;
    logic               push;
    logic               pop;

    // Buffered plus outstanding slots; one extra bit so the sum cannot wrap
    assign in_use      = {1'b0, fifo_count} + {1'b0, outst_q};
    assign fetch_req_o = !rst && !halt_i && !jump_flag_i && (in_use < (CNT_W + 1)'(DEPTH));
    assign fetch_addr_o = issue_pc_q;
    assign grant       = fetch_req_o && fetch_gnt_i;

    // A response is kept only outside a redirect and once all stale ones are gone
    assign push       = fetch_rvalid_i && !jump_flag_i && (discard_q == '0);
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && inst_ready_i && !jump_flag_i;

    always_comb begin
        issue_pc_d = issue_pc_q;
        fill_pc_d  = fill_pc_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CNT_W'(grant) - CNT_W'(fetch_rvalid_i);

        if (grant) begin
            issue_pc_d = issue_pc_q + ADDR_W'(4);
        end

        if (jump_flag_i) begin
            issue_pc_d = jump_addr_i;
            fill_pc_d  = jump_addr_i;
            // Everything still in flight belongs to the old stream; a response
            // arriving right now is dropped and already leaves the count.
            discard_d  = outst_q - CNT_W'(fetch_rvalid_i);
        end else if (fetch_rvalid_i) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CNT_W'(1);
            end else begin
                fill_pc_d = fill_pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_pc_q <= RESET_PC;
            fill_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            issue_pc_q <= issue_pc_d;
            fill_pc_q  <= fill_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    prefetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({fill_pc_q, fetch_rdata_i}),
        .pop_i   (pop),
        .flush_i (jump_flag_i),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign inst_valid_o = fifo_valid && !jump_flag_i;
    assign inst_o       = inst_valid_o ? fifo_head[INST_W-1:0] : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? fifo_head[ENTRY_W-1:INST_W] : '0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - randomized scoreboard bench for ifu_prefetch
module tb_ifu_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_gnt_i;
    logic        fetch_rvalid_i;
    logic [31:0] fetch_rdata_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        halt_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC),
        .INST_NOP (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req_o    (fetch_req_o),
        .fetch_addr_o   (fetch_addr_o),
        .fetch_gnt_i    (fetch_gnt_i),
        .fetch_rvalid_i (fetch_rvalid_i),
        .fetch_rdata_i  (fetch_rdata_i),
        .jump_flag_i    (jump_flag_i),
        .jump_addr_i    (jump_addr_i),
        .halt_i         (halt_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .inst_ready_i   (inst_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          cyc;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    // Model: bus requests in flight tagged with the stream epoch they belong to,
    // and the instructions expected at the decode side in order.
    req_t        pend[$];
    item_t       sb[$];
    logic [31:0] popped[$];
    item_t       mit;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          grants = 0;
    int          first_valid = -1;
    logic [31:0] m_pc = RPC;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int gp, input int rp, input int dp, input int jp, input int hp,
                        input bit fj, input logic [31:0] fja);
        bit    exp_req;
        bit    exp_valid;
        bit    do_jump;
        req_t  r;
        item_t it;
        @(negedge clk);
        rst          = 1'b0;
        halt_i       = ($urandom_range(99) < hp);
        do_jump      = fj || ($urandom_range(99) < jp);
        jump_flag_i  = do_jump;
        jump_addr_i  = fj ? fja : ($urandom & 32'h0000_fffc);
        fetch_gnt_i  = ($urandom_range(99) < gp);
        inst_ready_i = ($urandom_range(99) < dp);
        fetch_rvalid_i = 1'b0;
        fetch_rdata_i  = $urandom;
        if (pend.size() > 0) begin
            if (pend[0].cyc < cyc && $urandom_range(99) < rp) begin
                fetch_rvalid_i = 1'b1;
                fetch_rdata_i  = mem_data(pend[0].addr);
            end
        end
        #1;
        exp_req   = !halt_i && !do_jump && (sb.size() + pend.size() < DEPTH);
        exp_valid = (sb.size() != 0) && !do_jump;
        chk(fetch_req_o === exp_req, "fetch_req", 32'(fetch_req_o), 32'(exp_req));
        if (exp_req) chk(fetch_addr_o === m_pc, "fetch_addr", fetch_addr_o, m_pc);
        chk(inst_valid_o === exp_valid, "inst_valid", 32'(inst_valid_o), 32'(exp_valid));
        if (!exp_valid) begin
            chk(inst_o === NOP, "idle_inst", inst_o, NOP);
            chk(inst_addr_o === 32'h0, "idle_addr", inst_addr_o, 32'h0);
        end
        if (exp_valid && first_valid < 0) first_valid = cyc;
        @(posedge clk);
        if (exp_req && fetch_gnt_i) begin
            r.addr  = m_pc;
            r.epoch = epoch;
            r.cyc   = cyc;
            pend.push_back(r);
            m_pc = m_pc + 32'd4;
            grants++;
        end
        if (fetch_rvalid_i) begin
            r = pend.pop_front();
            if (!do_jump && r.epoch == epoch) begin
                it.addr = r.addr;
                it.data = mem_data(r.addr);
                sb.push_back(it);
            end
        end
        if (do_jump) begin
            epoch++;
            sb.delete();
            m_pc = jump_addr_i;
        end
        cyc++;
    endtask

    task automatic run(input int n, input int gp, input int rp, input int dp, input int jp, input int hp);
        for (int i = 0; i < n; i++) step(gp, rp, dp, jp, hp, 1'b0, 32'h0);
    endtask

    // Monitor: compares every accepted instruction against the scoreboard head
    always @(negedge clk) begin
        #2;
        if (!rst && inst_valid_o && inst_ready_i) begin
            if (sb.size() == 0) begin
                chk(1'b0, "pop_unexpected", inst_addr_o, 32'h0);
            end else begin
                mit = sb.pop_front();
                chk(inst_addr_o === mit.addr, "pop_addr", inst_addr_o, mit.addr);
                chk(inst_o === mit.data, "pop_data", inst_o, mit.data);
                popped.push_back(inst_addr_o);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        fetch_gnt_i    = 1'b1;
        fetch_rvalid_i = 1'b0;
        fetch_rdata_i  = '0;
        jump_flag_i    = 1'b0;
        jump_addr_i    = '0;
        halt_i         = 1'b0;
        inst_ready_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk(fetch_req_o === 1'b0, "reset_req", 32'(fetch_req_o), 32'h0);
            chk(inst_valid_o === 1'b0, "reset_valid", 32'(inst_valid_o), 32'h0);
            chk(inst_o === NOP, "reset_inst", inst_o, NOP);
            chk(inst_addr_o === 32'h0, "reset_addr", inst_addr_o, 32'h0);
        end

        // Streaming: first instruction two cycles after release, then one per cycle
        run(20, 100, 100, 100, 0, 0);
        chk(first_valid == 2, "first_valid_cycle", 32'(first_valid), 32'd2);
        chk(popped.size() == 18, "stream_count", 32'(popped.size()), 32'd18);
        if (popped.size() > 0) chk(popped[0] === RPC, "first_addr", popped[0], RPC);

        // Backpressure: DEPTH grants then stall; drain in order
        run(10, 0, 100, 100, 0, 0);
        grants = 0;
        run(12, 100, 100, 0, 0, 0);
        chk(grants == DEPTH, "backpressure_grants", 32'(grants), 32'(DEPTH));
        popped.delete();
        run(10, 0, 100, 100, 0, 0);
        chk(popped.size() == DEPTH, "backpressure_drain", 32'(popped.size()), 32'(DEPTH));

        // Redirect with three requests outstanding
        run(3, 100, 0, 0, 0, 0);
        step(100, 0, 0, 0, 0, 1'b1, 32'h2000);
        popped.delete();
        run(15, 100, 100, 100, 0, 0);
        if (popped.size() > 0) chk(popped[0] === 32'h2000, "redirect_addr", popped[0], 32'h2000);
        else chk(1'b0, "redirect_addr", 32'h0, 32'h2000);

        // Back-to-back redirects with responses in flight
        run(3, 100, 50, 100, 0, 0);
        step(100, 50, 100, 0, 0, 1'b1, 32'h40);
        step(100, 50, 100, 0, 0, 1'b1, 32'h80);
        popped.delete();
        run(15, 100, 100, 100, 0, 0);
        if (popped.size() > 0) chk(popped[0] === 32'h80, "double_redirect_addr", popped[0], 32'h80);
        else chk(1'b0, "double_redirect_addr", 32'h0, 32'h80);

        // Halt for 10 cycles mid-stream, then resume
        run(5, 100, 100, 100, 0, 0);
        grants = 0;
        run(10, 100, 100, 100, 0, 100);
        chk(grants == 0, "halt_grants", 32'(grants), 32'h0);
        run(10, 100, 100, 100, 0, 0);

        // Random traffic
        run(10000, 70, 60, 60, 3, 5);

        // Drain, then a full DEPTH of grants proves nothing is left outstanding
        run(30, 0, 100, 100, 0, 0);
        grants = 0;
        run(6, 100, 0, 0, 0, 0);
        chk(grants == DEPTH, "idle_outstanding", 32'(grants), 32'(DEPTH));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
